// File: rtl/divider_32bit_if.sv
// Request/response bundle for divider_32bit: start/operands in, registered results and status out.
interface divider_32bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;

    modport slave (
        input  start, A, B,
        output quotient, remainder, done, busy
    );

    modport master (
        output start, A, B,
        input  quotient, remainder, done, busy
    );
endinterface

// File: rtl/divider_32bit.sv
// Unsigned restoring divider, one quotient bit per clock, WIDTH cycles per operation.
// Optional macro DIVIDER_ZERO_FAST_EN: divide-by-zero completes one cycle after acceptance.
module divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    divider_32bit_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_done;
    logic             w_busy;

    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic             w_last;
    logic             w_finish;
    logic [WIDTH-1:0] w_quot_fin;
    logic [WIDTH-1:0] w_rem_fin;

    // r_dvd holds the dividend and fills with quotient bits from the LSB as it shifts out
    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_divisor});
    assign w_rem_nxt = w_ge ? WIDTH'(w_shift - {1'b0, r_divisor}) : w_shift[WIDTH-1:0];
    assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef DIVIDER_ZERO_FAST_EN
    logic r_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_zero <= 1'b0;
        else if (w_accept) r_zero <= (bus.B == '0);
    end

    // r_dvd is still the untouched dividend on the single fast-path RUN cycle
    assign w_finish   = w_last || r_zero;
    assign w_quot_fin = r_zero ? {WIDTH{1'b1}} : w_dvd_nxt;
    assign w_rem_fin  = r_zero ? r_dvd : w_rem_nxt;
`else
    assign w_finish   = w_last;
    assign w_quot_fin = w_dvd_nxt;
    assign w_rem_fin  = w_rem_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_finish)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divisor  <= '0;
            r_dvd      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_divisor <= bus.B;
                r_dvd     <= bus.A;
                r_rem     <= '0;
                r_cnt     <= '0;
            end else if (r_state == RUN) begin
                r_rem <= w_rem_nxt;
                r_dvd <= w_dvd_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (w_finish) begin
                    r_quot_out <= w_quot_fin;
                    r_rem_out  <= w_rem_fin;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign bus.quotient  = r_quot_out;
    assign bus.remainder = r_rem_out;
    assign bus.done      = r_done;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: stimulus pushes expected results, a negedge monitor checks them.
module tb_divider_32bit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           due;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [W-1:0] held_q;
    logic [W-1:0] held_r;

    divider_32bit_if #(.WIDTH(W)) dif ();

    divider_32bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: pops one expectation per done cycle, otherwise checks outputs are held
    always @(negedge clk) begin
        if (rst) begin
            held_q = '0;
            held_r = '0;
        end else if (dif.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", dif.quotient, e.q);
                chk("remainder", dif.remainder, e.r);
                chk("done_cycle", W'(cyc), W'(e.due));
                chk("busy_at_done", {31'b0, dif.busy}, '0);
                held_q = e.q;
                held_r = e.r;
            end
        end else begin
            chk("hold_quotient", dif.quotient, held_q);
            chk("hold_remainder", dif.remainder, held_r);
        end
    end

    function automatic int lat(input logic [W-1:0] b);
`ifdef DIVIDER_ZERO_FAST_EN
        return (b == '0) ? 1 : W;
`else
        return W + (b == '0 ? 0 : 0);
`endif
    endfunction

    // called at a negedge; acceptance happens on the next rising edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r);
        exp_t e;
        dif.start = 1'b1;
        dif.A     = a;
        dif.B     = b;
        e.q   = q;
        e.r   = r;
        e.due = cyc + 1 + lat(b);
        sb.push_back(e);
        @(negedge clk);
        dif.start = 1'b0;
        dif.A     = $urandom;
        dif.B     = $urandom;
        if (lat(b) > 1) chk("busy_after_start", {31'b0, dif.busy}, 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (dif.done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 100 cycles, expected a done pulse");
        end
    endtask

    vec_t vecs[11];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks = 0;
        errors = 0;
        held_q = '0;
        held_r = '0;
        rst = 1'b1;
        dif.start = 1'b0;
        dif.A = '0;
        dif.B = '0;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[2]  = '{32'h1234_5678,  32'hFFFF_FFFF,  32'd0,          32'h1234_5678};
        vecs[3]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[4]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};
        vecs[5]  = '{32'd7,          32'd100,        32'd0,          32'd7};
        vecs[6]  = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0};
        vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[8]  = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF};
        vecs[9]  = '{32'd1000,       32'd3,          32'd333,        32'd1};
        vecs[10] = '{32'd0,          32'd9,          32'd0,          32'd0};

        #1;
        chk("rst_quotient", dif.quotient, '0);
        chk("rst_remainder", dif.remainder, '0);
        chk("rst_done", {31'b0, dif.done}, '0);
        chk("rst_busy", {31'b0, dif.busy}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single op with idle gap, then back-to-back pair (start held on done cycle)
        issue(vecs[0].a, vecs[0].b, vecs[0].q, vecs[0].r);
        wait_done();
        @(negedge clk);
        issue(vecs[1].a, vecs[1].b, vecs[1].q, vecs[1].r);
        wait_done();
        issue(vecs[2].a, vecs[2].b, vecs[2].q, vecs[2].r);
        wait_done();
        for (int i = 3; i < 11; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
            wait_done();
            if (i[0]) @(negedge clk);
        end

        // start during RUN must be ignored
        @(negedge clk);
        issue(32'd50, 32'd5, 32'd10, 32'd0);
        repeat (9) @(negedge clk);
        dif.start = 1'b1;
        dif.A = 32'd9;
        dif.B = 32'd3;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // asynchronous reset mid-operation aborts without done
        issue(32'd1000, 32'd3, 32'd333, 32'd1);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_quotient", dif.quotient, '0);
        chk("abort_remainder", dif.remainder, '0);
        chk("abort_done", {31'b0, dif.done}, '0);
        chk("abort_busy", {31'b0, dif.busy}, '0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_busy_after", {31'b0, dif.busy}, '0);
        issue(32'd1000, 32'd3, 32'd333, 32'd1);
        wait_done();

        // random pairs, biased toward B=0 and B>A
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = '0;
                1:       rb = $urandom_range(255, 1);
                2:       rb = ra + 32'd1 + W'($urandom_range(1000));
                default: rb = $urandom;
            endcase
            if (rb == '0) issue(ra, rb, {W{1'b1}}, ra);
            else          issue(ra, rb, ra / rb, ra % rb);
            wait_done();
            if ((i % 3) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
